// File: rtl/operand_fetch_stage_pkg.sv
// Shared 8-bit pipeline definitions: datapath widths and opcode encodings
// used by decode, operand fetch, EX and writeback.
package operand_fetch_stage_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 3;
   localparam int OPC_W  = 8;
   localparam int CNT_W  = 16;

   localparam logic [OPC_W-1:0] OPC_NOP = 8'h00;
   localparam logic [OPC_W-1:0] OPC_ADD = 8'h01;
   localparam logic [OPC_W-1:0] OPC_SUB = 8'h02;
   localparam logic [OPC_W-1:0] OPC_AND = 8'h03;
   localparam logic [OPC_W-1:0] OPC_OR  = 8'h04;
   localparam logic [OPC_W-1:0] OPC_LD  = 8'h10;
   localparam logic [OPC_W-1:0] OPC_ST  = 8'h11;
   localparam logic [OPC_W-1:0] OPC_BEQ = 8'h20;

endpackage

// File: rtl/operand_fetch_stage_bypass_mux.sv
// Compare-and-select between register-file read data and the writeback value
// that the file will only commit on the next edge.
module operand_bypass_mux
   import operand_fetch_stage_pkg::*;
#(
   parameter int P_DATA_W = DATA_W,
   parameter int P_ADDR_W = ADDR_W
) (
   input  logic [P_ADDR_W-1:0] i_rs,
   input  logic [P_DATA_W-1:0] i_file_data,
   input  logic                i_wb_en,
   input  logic [P_ADDR_W-1:0] i_wb_reg,
   input  logic [P_DATA_W-1:0] i_wb_data,
   output logic [P_DATA_W-1:0] o_operand
);

   logic w_hit;

   // Register 0 is an ordinary register here, so no zero-index exclusion.
   assign w_hit     = i_wb_en && (i_wb_reg == i_rs);
   assign o_operand = w_hit ? i_wb_data : i_file_data;

endmodule

// File: rtl/operand_fetch_stage.sv
// ID/EX stage: drives register-file reads, bypasses same-cycle writeback,
// detects load-use hazards and holds the ID/EX pipeline register.
module operand_fetch_stage
   import operand_fetch_stage_pkg::*;
(
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [OPC_W-1:0]  in_opcode,
   input  logic [ADDR_W-1:0] in_rs1,
   input  logic [ADDR_W-1:0] in_rs2,
   input  logic [ADDR_W-1:0] in_rd,
   input  logic              in_uses_rs1,
   input  logic              in_uses_rs2,
   input  logic              in_mem_read,
   input  logic              in_reg_write,
   input  logic [DATA_W-1:0] in_imm,
   output logic [ADDR_W-1:0] read_reg1,
   output logic [ADDR_W-1:0] read_reg2,
   input  logic [DATA_W-1:0] read_data1,
   input  logic [DATA_W-1:0] read_data2,
   input  logic              wb_reg_write,
   input  logic [ADDR_W-1:0] wb_write_reg,
   input  logic [DATA_W-1:0] wb_write_data,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [OPC_W-1:0]  out_opcode,
   output logic [ADDR_W-1:0] out_rs1,
   output logic [ADDR_W-1:0] out_rs2,
   output logic [ADDR_W-1:0] out_rd,
   output logic              out_mem_read,
   output logic              out_reg_write,
   output logic [DATA_W-1:0] out_imm,
   output logic [DATA_W-1:0] out_op1,
   output logic [DATA_W-1:0] out_op2,
   output logic [CNT_W-1:0]  stall_count
);

   logic              r_out_valid;
   logic [OPC_W-1:0]  r_out_opcode;
   logic [ADDR_W-1:0] r_out_rs1;
   logic [ADDR_W-1:0] r_out_rs2;
   logic [ADDR_W-1:0] r_out_rd;
   logic              r_out_mem_read;
   logic              r_out_reg_write;
   logic [DATA_W-1:0] r_out_imm;
   logic [DATA_W-1:0] r_out_op1;
   logic [DATA_W-1:0] r_out_op2;
   logic [CNT_W-1:0]  r_stall_count;

   logic              w_hazard;
   logic              w_in_ready;
   logic              w_accept;
   logic [DATA_W-1:0] w_op1_next;
   logic [DATA_W-1:0] w_op2_next;

   assign read_reg1 = in_rs1;
   assign read_reg2 = in_rs2;

   operand_bypass_mux #(.P_DATA_W(DATA_W), .P_ADDR_W(ADDR_W)) u_bypass1 (
      .i_rs        (in_rs1),
      .i_file_data (read_data1),
      .i_wb_en     (wb_reg_write),
      .i_wb_reg    (wb_write_reg),
      .i_wb_data   (wb_write_data),
      .o_operand   (w_op1_next)
   );

   operand_bypass_mux #(.P_DATA_W(DATA_W), .P_ADDR_W(ADDR_W)) u_bypass2 (
      .i_rs        (in_rs2),
      .i_file_data (read_data2),
      .i_wb_en     (wb_reg_write),
      .i_wb_reg    (wb_write_reg),
      .i_wb_data   (wb_write_data),
      .o_operand   (w_op2_next)
   );

   // Only the instruction held in ID/EX is checked; EX->EX forwarding is downstream.
   assign w_hazard = r_out_valid && r_out_mem_read && r_out_reg_write &&
                     ((in_uses_rs1 && (r_out_rd == in_rs1)) ||
                      (in_uses_rs2 && (r_out_rd == in_rs2)));

   assign w_in_ready = reset_n && (!r_out_valid || out_ready) && !w_hazard && !flush;
   assign w_accept   = in_valid && w_in_ready;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_out_valid     <= 1'b0;
         r_out_opcode    <= '0;
         r_out_rs1       <= '0;
         r_out_rs2       <= '0;
         r_out_rd        <= '0;
         r_out_mem_read  <= 1'b0;
         r_out_reg_write <= 1'b0;
         r_out_imm       <= '0;
         r_out_op1       <= '0;
         r_out_op2       <= '0;
         r_stall_count   <= '0;
      end else begin
         if (flush) begin
            r_out_valid <= 1'b0;
         end else if (w_accept) begin
            r_out_valid     <= 1'b1;
            r_out_opcode    <= in_opcode;
            r_out_rs1       <= in_rs1;
            r_out_rs2       <= in_rs2;
            r_out_rd        <= in_rd;
            r_out_mem_read  <= in_mem_read;
            r_out_reg_write <= in_reg_write;
            r_out_imm       <= in_imm;
            r_out_op1       <= w_op1_next;
            r_out_op2       <= w_op2_next;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end

         if (in_valid && w_hazard && !flush && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + CNT_W'(1);
         end
      end
   end

   assign in_ready      = w_in_ready;
   assign out_valid     = r_out_valid;
   assign out_opcode    = r_out_opcode;
   assign out_rs1       = r_out_rs1;
   assign out_rs2       = r_out_rs2;
   assign out_rd        = r_out_rd;
   assign out_mem_read  = r_out_mem_read;
   assign out_reg_write = r_out_reg_write;
   assign out_imm       = r_out_imm;
   assign out_op1       = r_out_op1;
   assign out_op2       = r_out_op2;
   assign stall_count   = r_stall_count;

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Scoreboard bench for operand_fetch_stage: a behavioural register file and
// ID/EX-slot model predict handshakes, operands and the stall counter.
module tb_operand_fetch_stage;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_opcode;
   logic [2:0]  in_rs1, in_rs2, in_rd;
   logic        in_uses_rs1, in_uses_rs2, in_mem_read, in_reg_write;
   logic [7:0]  in_imm;
   logic [2:0]  read_reg1, read_reg2;
   logic [7:0]  read_data1, read_data2;
   logic        wb_reg_write;
   logic [2:0]  wb_write_reg;
   logic [7:0]  wb_write_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  out_opcode;
   logic [2:0]  out_rs1, out_rs2, out_rd;
   logic        out_mem_read, out_reg_write;
   logic [7:0]  out_imm, out_op1, out_op2;
   logic [15:0] stall_count;

   operand_fetch_stage dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
      .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2),
      .in_mem_read(in_mem_read), .in_reg_write(in_reg_write), .in_imm(in_imm),
      .read_reg1(read_reg1), .read_reg2(read_reg2),
      .read_data1(read_data1), .read_data2(read_data2),
      .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg),
      .wb_write_data(wb_write_data), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_opcode(out_opcode), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_rd(out_rd), .out_mem_read(out_mem_read),
      .out_reg_write(out_reg_write), .out_imm(out_imm),
      .out_op1(out_op1), .out_op2(out_op2), .stall_count(stall_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [7:0] opc;
      logic [2:0] rs1, rs2, rd;
      logic       mr, rw;
      logic [7:0] imm, op1, op2;
   } pkt_t;

   pkt_t        q[$];
   logic [7:0]  rf [8];
   int          checks = 0;
   int          failures = 0;

   // Model of the ID/EX slot: only what the hazard and drain rules need.
   bit          m_valid = 0;
   bit          m_mr = 0, m_rw = 0;
   logic [2:0]  m_rd = '0;
   logic [15:0] m_stall = '0;

   always_comb begin
      read_data1 = rf[read_reg1];
      read_data2 = rf[read_reg2];
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Value a register holds once this cycle's writeback has committed.
   function automatic logic [7:0] newest(input logic [2:0] idx);
      if (wb_reg_write && wb_write_reg == idx) return wb_write_data;
      return rf[idx];
   endfunction

   // One clock cycle: inputs are already driven (just after a negedge).
   task automatic step(input bit chk);
      bit   hz, exp_rdy, wbe;
      logic [2:0] wr;
      logic [7:0] wd;
      pkt_t p;
      #1;
      hz = m_valid && m_mr && m_rw &&
           ((in_uses_rs1 && m_rd == in_rs1) || (in_uses_rs2 && m_rd == in_rs2));
      exp_rdy = reset_n && (!m_valid || out_ready) && !hz && !flush;
      if (chk) begin
         check("in_ready", 64'(in_ready), 64'(exp_rdy));
         check("out_valid", 64'(out_valid), 64'(m_valid));
         check("stall_count", 64'(stall_count), 64'(m_stall));
      end
      if (!reset_n) begin
         m_valid = 0;
         m_stall = '0;
         q.delete();
      end else begin
         if (in_valid && hz && !flush && m_stall != 16'hFFFF) m_stall++;
         if (flush) begin
            if (m_valid && q.size() > 0) void'(q.pop_front());
            m_valid = 0;
         end else if (in_valid && exp_rdy) begin
            p.opc = in_opcode; p.rs1 = in_rs1; p.rs2 = in_rs2; p.rd = in_rd;
            p.mr = in_mem_read; p.rw = in_reg_write; p.imm = in_imm;
            p.op1 = newest(in_rs1); p.op2 = newest(in_rs2);
            q.push_back(p);
            m_valid = 1; m_mr = in_mem_read; m_rw = in_reg_write; m_rd = in_rd;
         end else if (m_valid && out_ready) begin
            m_valid = 0;
         end
      end
      wbe = wb_reg_write; wr = wb_write_reg; wd = wb_write_data;
      @(posedge clk);
      #1;
      if (wbe) rf[wr] = wd;
      @(negedge clk);
   endtask

   // Monitor: whenever EX consumes the held instruction, compare it.
   initial begin
      pkt_t e;
      forever begin
         @(negedge clk);
         #2;
         if (reset_n === 1'b1 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
               check("scoreboard_underflow", 64'(q.size()), 64'd1);
            end else begin
               e = q.pop_front();
               check("out_op1", 64'(out_op1), 64'(e.op1));
               check("out_op2", 64'(out_op2), 64'(e.op2));
               check("out_ctrl", 64'({out_opcode, out_rs1, out_rs2, out_rd, out_mem_read, out_reg_write, out_imm}),
                     64'({e.opc, e.rs1, e.rs2, e.rd, e.mr, e.rw, e.imm}));
            end
         end
      end
   end

   task automatic idle_inputs();
      in_valid = 0; in_opcode = '0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
      in_uses_rs1 = 0; in_uses_rs2 = 0; in_mem_read = 0; in_reg_write = 0;
      in_imm = '0; wb_reg_write = 0; wb_write_reg = '0; wb_write_data = '0;
      flush = 0; out_ready = 1;
   endtask

   task automatic instr(input logic [7:0] opc, input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic [2:0] rd, input bit u1, input bit u2, input bit mr, input bit rw);
      in_valid = 1; in_opcode = opc; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
      in_uses_rs1 = u1; in_uses_rs2 = u2; in_mem_read = mr; in_reg_write = rw;
      in_imm = 8'($urandom);
   endtask

   task automatic rand_inputs();
      instr(8'($urandom), 3'($urandom), 3'($urandom), 3'($urandom),
            1'($urandom), 1'($urandom), $urandom_range(9) < 4, $urandom_range(9) < 7);
      in_valid      = $urandom_range(3) != 0;
      wb_reg_write  = 1'($urandom);
      wb_write_reg  = 3'($urandom);
      wb_write_data = 8'($urandom);
      flush         = $urandom_range(9) == 0;
      out_ready     = $urandom_range(9) < 7;
      reset_n       = $urandom_range(99) != 0;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) rf[i] = 8'($urandom);
      reset_n = 0;
      idle_inputs();
      @(negedge clk);
      step(0);
      step(1);
      reset_n = 1;

      // Same-cycle writeback bypass
      rf[3] = 8'h11;
      instr(8'h01, 3'd3, 3'd0, 3'd5, 1, 0, 0, 1);
      wb_reg_write = 1; wb_write_reg = 3'd3; wb_write_data = 8'h5A;
      step(1);
      check("bypass_op1", 64'(out_op1), 64'h5A);
      idle_inputs();

      // Load-use: one bubble, one stall cycle
      instr(8'h10, 3'd0, 3'd0, 3'd2, 0, 0, 1, 1);
      step(1);
      instr(8'h02, 3'd6, 3'd2, 3'd4, 0, 1, 0, 1);
      step(1);
      check("loaduse_bubble", 64'(out_valid), 64'd0);
      check("loaduse_stall", 64'(stall_count), 64'd1);
      step(1);
      check("loaduse_accept", 64'(out_valid), 64'd1);

      // Back-pressure for three cycles, then accept on release
      instr(8'h03, 3'd1, 3'd7, 3'd6, 1, 1, 0, 1);
      out_ready = 0;
      repeat (3) step(1);
      out_ready = 1;
      step(1);

      // Flush squashes held and decode instruction; decode re-presented
      instr(8'h04, 3'd5, 3'd1, 3'd3, 1, 1, 0, 1);
      flush = 1;
      step(1);
      check("flush_valid", 64'(out_valid), 64'd0);
      flush = 0;
      step(1);
      check("flush_reaccept", 64'(out_valid), 64'd1);

      // Build stall_count to 5 then reset mid-stream
      instr(8'h10, 3'd0, 3'd0, 3'd1, 0, 0, 1, 1);
      step(1);
      instr(8'h01, 3'd1, 3'd0, 3'd2, 1, 0, 0, 1);
      out_ready = 0;
      repeat (4) step(1);
      check("stall_pre_reset", 64'(stall_count), 64'd5);
      reset_n = 0;
      step(1);
      check("reset_valid", 64'(out_valid), 64'd0);
      check("reset_stall", 64'(stall_count), 64'd0);
      check("reset_payload", 64'({out_opcode, out_rs1, out_rs2, out_rd, out_mem_read,
                                  out_reg_write, out_imm, out_op1, out_op2}), 64'd0);
      reset_n = 1;
      idle_inputs();

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rand_inputs();
         step(1);
      end

      // Saturation of the stall counter
      idle_inputs();
      reset_n = 0;
      step(1);
      reset_n = 1;
      instr(8'h10, 3'd0, 3'd0, 3'd4, 0, 0, 1, 1);
      step(1);
      instr(8'h01, 3'd4, 3'd4, 3'd0, 1, 1, 0, 1);
      out_ready = 0;
      for (int n = 0; n < 65540; n++) step(n % 4096 == 0);
      step(1);
      check("stall_saturate", 64'(stall_count), 64'hFFFF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- ID/EX stage of the 8-bit pipeline; the read-side client of the register file.
- Drives the two register-file read addresses and captures the returned operands into the ID/EX pipeline register.
- Bypasses the same-cycle writeback value, which the file only commits on the next edge.
- Stalls decode on a load-use hazard and talks valid/ready to both neighbours.

Parameters:
- DATA_W, 8, register and operand width
- ADDR_W, 3, register index width (8 registers)
- OPC_W, 8, opcode field width passed through to EX
- CNT_W, 16, stall performance counter width

Ports:
- clk  in  1  clock; all state updates on posedge
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_opcode  in  OPC_W  decoded opcode
- in_rs1, in_rs2, in_rd  in  ADDR_W  source and destination indices
- in_uses_rs1, in_uses_rs2  in  1  instruction actually reads rs1 / rs2
- in_mem_read  in  1  instruction is a load
- in_reg_write  in  1  instruction writes rd
- in_imm  in  DATA_W  immediate
- read_reg1, read_reg2  out  ADDR_W  register-file read addresses
- read_data1, read_data2  in  DATA_W  register-file read data (combinational)
- wb_reg_write  in  1  writeback write enable (same signal that drives the file)
- wb_write_reg  in  ADDR_W  writeback index
- wb_write_data  in  DATA_W  writeback data
- flush  in  1  squash the held instruction (branch taken)
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  EX consumes the instruction
- out_opcode, out_rs1, out_rs2, out_rd, out_mem_read, out_reg_write, out_imm  out  –  registered copies of the inputs
- out_op1, out_op2  out  DATA_W  registered operands
- stall_count  out  CNT_W  cycles lost to load-use stalls

Behaviour:
- Read addresses: read_reg1 = in_rs1 and read_reg2 = in_rs2, combinationally, every cycle regardless of in_valid.
- Bypass: op1_next = wb_write_data when wb_reg_write && wb_write_reg == in_rs1, otherwise read_data1. op2_next follows the same rule with rs2. Register 0 is not special.
- Hazard: hazard = out_valid && out_mem_read && out_reg_write && ((in_uses_rs1 && out_rd == in_rs1) || (in_uses_rs2 && out_rd == in_rs2)). The check is against the ID/EX-held instruction only; EX→EX forwarding belongs downstream.
- in_ready = (!out_valid || out_ready) && !hazard && !flush. It is combinational and never depends on in_valid.
- accept = in_valid && in_ready. On accept, every out_* register loads its input or op*_next, and out_valid becomes 1 on the next edge.
- Drain: out_valid && out_ready && !accept → out_valid becomes 0. A hazard therefore inserts exactly one bubble; the payload registers hold their value.
- Hold: out_valid && !out_ready → all out_* registers hold. in_ready is 0.
- Flush: flush wins over accept and hold. On the next edge out_valid = 0 and decode is not accepted that cycle.
- stall_count: increments by 1 each cycle with in_valid && hazard && !flush, and saturates at all-ones.
- Reset (reset_n low at posedge): out_valid = 0, all out_* = 0, stall_count = 0. A held instruction is dropped with no partial update. in_ready is 0 while reset_n is low.
- Latency: 1 cycle from accept to out_valid. Throughput is 1 instruction per cycle when there is no hazard and out_ready is held high.

Decomposition:
- Shared pipeline package holds DATA_W, ADDR_W, OPC_W and the opcode constants, used by decode, EX and writeback.
- One natural sub-module: operand_bypass_mux, instanced twice. It is the combinational compare-and-select of file data versus writeback data.
- The hazard detect and the pipeline register stay in the top module.

Test Plan:
- Bypass: file r3 = 0x11; in the same cycle wb writes r3 = 0x5A while an instruction with rs1 = 3 is accepted → out_op1 = 0x5A next cycle, not 0x11.
- Load-use: a load with rd = 2 is held in ID/EX; the next instruction has uses_rs2, rs2 = 2, out_ready = 1 → in_ready = 0 for 1 cycle, out_valid = 0 bubble, stall_count = 1, then accept.
- Back-pressure: out_ready = 0 for 3 cycles with out_valid = 1 → in_ready = 0, out_* stable; then out_ready = 1 → the next instruction is accepted in the same cycle.
- Flush: flush = 1 with in_valid = 1 and out_valid = 1 → next cycle out_valid = 0, the decode instruction is not consumed, and it is re-presented and accepted one cycle later.
- Reset: reset_n = 0 mid-stream with out_valid = 1 and stall_count = 5 → next edge out_valid = 0, stall_count = 0, outputs 0.
- Saturation: force 65540 hazard cycles → stall_count stays at 0xFFFF.
